// File: rtl/cpu_bus_frontend.sv
// Z80 pin front end: synchronizes and deglitches the raw strobes onto clk28, delays
// address/data to stay aligned with them, and classifies each machine cycle.
module cpu_bus_frontend #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 2
) (
   input  logic        clk28,
   input  logic        rst_n,
   input  logic        n_iorq_pin,
   input  logic        n_mreq_pin,
   input  logic        n_m1_pin,
   input  logic        n_rfsh_pin,
   input  logic        n_rd_pin,
   input  logic        n_wr_pin,
   input  logic [15:0] a_pin,
   input  logic [7:0]  d_pin,
   output logic [15:0] a_raw,
   output logic [15:0] a,
   output logic [7:0]  d,
   output logic        iorq,
   output logic        mreq,
   output logic        m1,
   output logic        rfsh,
   output logic        rd,
   output logic        wr,
   output logic        ioreq,
   output logic        memreq,
   output logic        memreq_rise,
   output logic        ioreq_rise,
   output logic [2:0]  cycle,
   output logic        bus_err
);

   localparam int unsigned LAT    = SYNC_STAGES + FILTER_LEN;
   localparam int unsigned NSTB   = 6;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned AW     = 16;
   localparam int unsigned DW     = 8;
   localparam int unsigned I_IORQ = 0;
   localparam int unsigned I_MREQ = 1;
   localparam int unsigned I_M1   = 2;
   localparam int unsigned I_RFSH = 3;
   localparam int unsigned I_RD   = 4;
   localparam int unsigned I_WR   = 5;

   typedef enum logic [2:0] {
      CYC_IDLE    = 3'd0,
      CYC_MEM_RD  = 3'd1,
      CYC_MEM_WR  = 3'd2,
      CYC_IO_RD   = 3'd3,
      CYC_IO_WR   = 3'd4,
      CYC_INTACK  = 3'd5,
      CYC_REFRESH = 3'd6
   } cycle_e;

   logic [NSTB-1:0]  w_pins_n;
   logic [NSTB-1:0]  w_sync_act;
   logic [NSTB-1:0]  r_sync [SYNC_STAGES];
   logic [NSTB-1:0]  r_strobe;
   logic [CNT_W-1:0] r_cnt [NSTB];
   logic [AW-1:0]    r_a_pipe [LAT];
   logic [DW-1:0]    r_d_pipe [LAT];
   logic [AW-1:0]    r_a_hold;
   logic             r_memreq_q;
   logic             r_ioreq_q;
   logic             r_bus_err;
   logic             w_bus_fault;
   cycle_e           r_cycle;

   assign w_pins_n   = {n_wr_pin, n_rd_pin, n_rfsh_pin, n_m1_pin, n_mreq_pin, n_iorq_pin};
   assign w_sync_act = ~r_sync[SYNC_STAGES-1];

   // Sync chain plus run-length filter: a strobe flips only after FILTER_LEN disagreeing samples
   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '1;
         for (int i = 0; i < NSTB; i++) r_cnt[i] <= '0;
         r_strobe <= '0;
      end else begin
         r_sync[0] <= w_pins_n;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         for (int i = 0; i < NSTB; i++) begin
            if (w_sync_act[i] == r_strobe[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
               r_strobe[i] <= ~r_strobe[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Address/data delay line matching the strobe latency; a is frozen across refresh
   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) begin
            r_a_pipe[k] <= '0;
            r_d_pipe[k] <= '0;
         end
         r_a_hold <= '0;
      end else begin
         r_a_pipe[0] <= a_pin;
         r_d_pipe[0] <= d_pin;
         for (int k = 1; k < LAT; k++) begin
            r_a_pipe[k] <= r_a_pipe[k-1];
            r_d_pipe[k] <= r_d_pipe[k-1];
         end
         if (!rfsh) r_a_hold <= a_raw;
      end
   end

   assign iorq  = r_strobe[I_IORQ];
   assign mreq  = r_strobe[I_MREQ];
   assign m1    = r_strobe[I_M1];
   assign rfsh  = r_strobe[I_RFSH];
   assign rd    = r_strobe[I_RD];
   assign wr    = r_strobe[I_WR];
   assign a_raw = r_a_pipe[LAT-1];
   assign d     = r_d_pipe[LAT-1];
   assign a     = rfsh ? r_a_hold : a_raw;

   assign memreq      = mreq & (rd | wr) & ~rfsh;
   assign ioreq       = iorq & (rd | wr) & ~m1;
   assign memreq_rise = memreq & ~r_memreq_q;
   assign ioreq_rise  = ioreq & ~r_ioreq_q;
   assign w_bus_fault = (mreq & iorq) | ((mreq | iorq) & rd & wr);

   // Cycle classifier; memory wins over I/O and rd wins over wr when both appear
   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         r_cycle    <= CYC_IDLE;
         r_memreq_q <= 1'b0;
         r_ioreq_q  <= 1'b0;
         r_bus_err  <= 1'b0;
      end else begin
         r_memreq_q <= memreq;
         r_ioreq_q  <= ioreq;
         if (w_bus_fault) r_bus_err <= 1'b1;
         case (r_cycle)
            CYC_IDLE: begin
               if (mreq && rfsh)    r_cycle <= CYC_REFRESH;
               else if (memreq_rise) r_cycle <= rd ? CYC_MEM_RD : CYC_MEM_WR;
               else if (iorq && m1)  r_cycle <= CYC_INTACK;
               else if (ioreq_rise)  r_cycle <= rd ? CYC_IO_RD : CYC_IO_WR;
            end
            CYC_MEM_RD, CYC_MEM_WR, CYC_REFRESH: begin
               if (!mreq) r_cycle <= CYC_IDLE;
            end
            default: begin
               if (!iorq) r_cycle <= CYC_IDLE;
            end
         endcase
      end
   end

   assign cycle   = r_cycle;
   assign bus_err = r_bus_err;

endmodule

// File: tb/tb_cpu_bus_frontend.sv
// Bench for cpu_bus_frontend: directed Z80 bus scenarios followed by random traffic,
// every cycle compared against a pin-history reference model.
module tb_cpu_bus_frontend;

   localparam int S  = 2;
   localparam int F  = 2;
   localparam int L  = S + F;
   localparam int HD = 16;
   localparam int B_IO = 0, B_MR = 1, B_M1 = 2, B_RF = 3, B_RD = 4, B_WR = 5;

   logic        clk28;
   logic        rst_n;
   logic        n_iorq_pin, n_mreq_pin, n_m1_pin, n_rfsh_pin, n_rd_pin, n_wr_pin;
   logic [15:0] a_pin;
   logic [7:0]  d_pin;
   logic [15:0] a_raw, a;
   logic [7:0]  d;
   logic        iorq, mreq, m1, rfsh, rd, wr;
   logic        ioreq, memreq, memreq_rise, ioreq_rise;
   logic [2:0]  cycle;
   logic        bus_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: pin history (index 0 = pins seen at the latest edge)
   logic [5:0]  h_pins [HD];
   logic [15:0] h_a [HD];
   logic [7:0]  h_d [HD];
   logic [5:0]  m_str;
   logic [15:0] m_a_raw, m_hold;
   logic [7:0]  m_d;
   int          m_cycle;
   logic        m_err, m_memreq_q, m_ioreq_q;

   cpu_bus_frontend #(.SYNC_STAGES(S), .FILTER_LEN(F)) dut (
      .clk28(clk28), .rst_n(rst_n),
      .n_iorq_pin(n_iorq_pin), .n_mreq_pin(n_mreq_pin), .n_m1_pin(n_m1_pin),
      .n_rfsh_pin(n_rfsh_pin), .n_rd_pin(n_rd_pin), .n_wr_pin(n_wr_pin),
      .a_pin(a_pin), .d_pin(d_pin),
      .a_raw(a_raw), .a(a), .d(d),
      .iorq(iorq), .mreq(mreq), .m1(m1), .rfsh(rfsh), .rd(rd), .wr(wr),
      .ioreq(ioreq), .memreq(memreq), .memreq_rise(memreq_rise), .ioreq_rise(ioreq_rise),
      .cycle(cycle), .bus_err(bus_err)
   );

   initial clk28 = 1'b0;
   always #5 clk28 = ~clk28;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic req_mem(input logic [5:0] s);
      return s[B_MR] & (s[B_RD] | s[B_WR]) & ~s[B_RF];
   endfunction

   function automatic logic req_io(input logic [5:0] s);
      return s[B_IO] & (s[B_RD] | s[B_WR]) & ~s[B_M1];
   endfunction

   // Classification rules: 0 idle,1 mem rd,2 mem wr,3 io rd,4 io wr,5 intack,6 refresh
   function automatic int next_cycle(input int cur, input logic [5:0] s,
                                     input logic mrise, input logic irise);
      if (cur == 0) begin
         if (s[B_MR] && s[B_RF]) return 6;
         if (mrise)              return s[B_RD] ? 1 : 2;
         if (s[B_IO] && s[B_M1]) return 5;
         if (irise)              return s[B_RD] ? 3 : 4;
         return 0;
      end
      if (cur == 1 || cur == 2 || cur == 6) return s[B_MR] ? cur : 0;
      return s[B_IO] ? cur : 0;
   endfunction

   task automatic step();
      logic [5:0] old;
      logic       o_mem, o_io, all_diff;
      @(posedge clk28);
      if (!rst_n) begin
         for (int k = 0; k < HD; k++) begin
            h_pins[k] = '1; h_a[k] = '0; h_d[k] = '0;
         end
         m_str = '0; m_a_raw = '0; m_d = '0; m_hold = '0;
         m_cycle = 0; m_err = 1'b0; m_memreq_q = 1'b0; m_ioreq_q = 1'b0;
      end else begin
         old   = m_str;
         o_mem = req_mem(old);
         o_io  = req_io(old);
         m_cycle = next_cycle(m_cycle, old, o_mem & ~m_memreq_q, o_io & ~m_ioreq_q);
         if ((old[B_MR] & old[B_IO]) | ((old[B_MR] | old[B_IO]) & old[B_RD] & old[B_WR]))
            m_err = 1'b1;
         m_memreq_q = o_mem;
         m_ioreq_q  = o_io;
         if (!old[B_RF]) m_hold = m_a_raw;
         for (int k = HD - 1; k > 0; k--) begin
            h_pins[k] = h_pins[k-1]; h_a[k] = h_a[k-1]; h_d[k] = h_d[k-1];
         end
         h_pins[0] = {n_wr_pin, n_rd_pin, n_rfsh_pin, n_m1_pin, n_mreq_pin, n_iorq_pin};
         h_a[0] = a_pin;
         h_d[0] = d_pin;
         // A strobe flips once its last F synchronized samples all disagree with it
         for (int i = 0; i < 6; i++) begin
            all_diff = 1'b1;
            for (int k = S; k < S + F; k++)
               if (~h_pins[k][i] == m_str[i]) all_diff = 1'b0;
            if (all_diff) m_str[i] = ~m_str[i];
         end
         m_a_raw = h_a[L-1];
         m_d     = h_d[L-1];
      end
      #1;
      chk("strobes", 16'({wr, rd, rfsh, m1, mreq, iorq}), 16'(m_str));
      chk("a_raw", a_raw, m_a_raw);
      chk("a", a, m_str[B_RF] ? m_hold : m_a_raw);
      chk("d", 16'(d), 16'(m_d));
      chk("memreq", 16'(memreq), 16'(req_mem(m_str)));
      chk("ioreq", 16'(ioreq), 16'(req_io(m_str)));
      chk("memreq_rise", 16'(memreq_rise), 16'(req_mem(m_str) & ~m_memreq_q));
      chk("ioreq_rise", 16'(ioreq_rise), 16'(req_io(m_str) & ~m_ioreq_q));
      chk("cycle", 16'(cycle), 16'(m_cycle));
      chk("bus_err", 16'(bus_err), 16'(m_err));
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic idle_pins();
      {n_wr_pin, n_rd_pin, n_rfsh_pin, n_m1_pin, n_mreq_pin, n_iorq_pin} = '1;
   endtask

   initial begin
      int kind, len, cnt_io, cnt_rise;
      rst_n = 1'b0;
      idle_pins();
      a_pin = 16'h0; d_pin = 8'h0;

      // Reset state
      hold(2);
      chk("rst_cycle", 16'(cycle), 16'd0);
      chk("rst_bus_err", 16'(bus_err), 16'd0);
      chk("rst_a_raw", a_raw, 16'h0);

      // Memory read: memreq after L edges, one-cycle rise, MEM_RD one edge later
      rst_n = 1'b1;
      n_mreq_pin = 1'b0; n_rd_pin = 1'b0; a_pin = 16'h1234;
      hold(3);
      chk("rd_memreq_early", 16'(memreq), 16'd0);
      step();
      chk("rd_memreq", 16'(memreq), 16'd1);
      chk("rd_rise", 16'(memreq_rise), 16'd1);
      chk("rd_a_raw", a_raw, 16'h1234);
      chk("rd_a", a, 16'h1234);
      step();
      chk("rd_rise_gone", 16'(memreq_rise), 16'd0);
      chk("rd_cycle", 16'(cycle), 16'd1);
      hold(1);
      idle_pins();
      hold(6);
      chk("rd_end_cycle", 16'(cycle), 16'd0);

      // Memory write with wr trailing mreq by two cycles
      n_mreq_pin = 1'b0; a_pin = 16'h4000;
      hold(2);
      n_wr_pin = 1'b0; d_pin = 8'hA5;
      hold(3);
      chk("wr_memreq_early", 16'(memreq), 16'd0);
      step();
      chk("wr_rise", 16'(memreq_rise), 16'd1);
      chk("wr_d", 16'(d), 16'h00A5);
      step();
      chk("wr_cycle", 16'(cycle), 16'd2);
      hold(1);
      idle_pins();
      hold(5);
      chk("wr_end_cycle", 16'(cycle), 16'd0);

      // Opcode fetch then refresh: a keeps the fetch address
      n_m1_pin = 1'b0; n_mreq_pin = 1'b0; n_rd_pin = 1'b0; a_pin = 16'h0038;
      hold(6);
      chk("m1_cycle", 16'(cycle), 16'd1);
      idle_pins();
      n_rfsh_pin = 1'b0; a_pin = 16'h7F12;
      hold(3);
      n_mreq_pin = 1'b0;
      hold(8);
      chk("rf_a_raw", a_raw, 16'h7F12);
      chk("rf_a", a, 16'h0038);
      chk("rf_memreq", 16'(memreq), 16'd0);
      chk("rf_cycle", 16'(cycle), 16'd6);
      idle_pins();
      hold(6);

      // One-cycle iorq glitch is dropped; a two-cycle pulse passes
      n_rd_pin = 1'b0; n_iorq_pin = 1'b0;
      step();
      n_iorq_pin = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         chk("glitch_iorq", 16'(iorq), 16'd0);
         chk("glitch_ioreq_rise", 16'(ioreq_rise), 16'd0);
      end
      n_iorq_pin = 1'b0;
      hold(2);
      n_iorq_pin = 1'b1;
      cnt_io = 0; cnt_rise = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (iorq) cnt_io++;
         if (ioreq_rise) cnt_rise++;
      end
      chk("pulse_iorq_len", 16'(cnt_io), 16'd2);
      chk("pulse_ioreq_rise", 16'(cnt_rise), 16'd1);
      idle_pins();
      hold(6);

      // Port read, then interrupt acknowledge
      n_iorq_pin = 1'b0; n_rd_pin = 1'b0; a_pin = 16'h00FE;
      hold(6);
      chk("io_ioreq", 16'(ioreq), 16'd1);
      chk("io_cycle", 16'(cycle), 16'd3);
      chk("io_a", a, 16'h00FE);
      idle_pins();
      hold(6);
      n_iorq_pin = 1'b0; n_m1_pin = 1'b0;
      hold(6);
      chk("ack_cycle", 16'(cycle), 16'd5);
      chk("ack_ioreq", 16'(ioreq), 16'd0);
      idle_pins();
      hold(6);

      // Illegal mreq+iorq: memory wins, sticky error until reset
      n_mreq_pin = 1'b0; n_iorq_pin = 1'b0; n_rd_pin = 1'b0;
      hold(6);
      chk("both_cycle", 16'(cycle), 16'd1);
      chk("both_err", 16'(bus_err), 16'd1);
      idle_pins();
      hold(6);
      chk("err_sticky", 16'(bus_err), 16'd1);
      n_mreq_pin = 1'b0; n_rd_pin = 1'b0; a_pin = 16'hBEEF; d_pin = 8'h5A;
      hold(5);
      rst_n = 1'b0;
      step();
      chk("mid_rst_cycle", 16'(cycle), 16'd0);
      chk("mid_rst_err", 16'(bus_err), 16'd0);
      chk("mid_rst_a", a, 16'h0);
      chk("mid_rst_memreq", 16'(memreq), 16'd0);
      chk("mid_rst_mreq", 16'(mreq), 16'd0);
      rst_n = 1'b1;
      hold(3);
      chk("requal_early", 16'(memreq), 16'd0);
      step();
      chk("requal_memreq", 16'(memreq), 16'd1);
      idle_pins();
      hold(6);

      // Random Z80-like traffic with short glitches, noise and one reset
      for (int t = 0; t < 60; t++) begin
         kind  = int'($urandom_range(0, 6));
         len   = int'($urandom_range(1, 7));
         a_pin = 16'($urandom);
         d_pin = 8'($urandom);
         case (kind)
            0: begin n_mreq_pin = 1'b0; n_rd_pin = 1'b0; end
            1: begin n_mreq_pin = 1'b0; step(); n_wr_pin = 1'b0; end
            2: begin n_iorq_pin = 1'b0; n_rd_pin = 1'b0; end
            3: begin n_iorq_pin = 1'b0; n_wr_pin = 1'b0; end
            4: begin n_iorq_pin = 1'b0; n_m1_pin = 1'b0; end
            5: begin n_rfsh_pin = 1'b0; n_mreq_pin = 1'b0; end
            default: begin
               for (int i = 0; i < len; i++) begin
                  {n_wr_pin, n_rd_pin, n_rfsh_pin, n_m1_pin, n_mreq_pin, n_iorq_pin} = 6'($urandom);
                  a_pin = 16'($urandom);
                  d_pin = 8'($urandom);
                  step();
               end
            end
         endcase
         hold(len);
         if (t == 30) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
         end
         idle_pins();
         hold(int'($urandom_range(0, 6)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
